vector_point_sequencer: RTL and testbench

Sequencer between the display-list point stream and the vector datapath: the Bresenham line stepper and the dual-channel 12-bit SPI DAC (channel A = X, channel B = Y). It accepts one destination point per handshake, strobes the stepper, and advances it one step at a time. After each step it writes only the axis that changed to the DAC and waits for the DAC to finish before the next step. It drives the beam blank output and inserts a settle delay after blanked moves.

---
 rtl/vector_point_sequencer_if.sv | 29 ++
 rtl/vector_point_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vector_point_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_point_sequencer_if.sv
// Point-stream handshake between the display-list reader and the vector
// sequencer. One destination point moves per pt_valid && pt_ready cycle.
interface vector_point_sequencer_if #(
    parameter int BITS = 12
);
    logic            pt_valid;
    logic [BITS-1:0] pt_x;
    logic [BITS-1:0] pt_y;
    logic            pt_blank;
    logic            pt_ready;

    // Point source (display-list side)
    modport master (
        output pt_valid,
        output pt_x,
        output pt_y,
        output pt_blank,
        input  pt_ready
    );

    // Point sink (sequencer side)
    modport slave (
        input  pt_valid,
        input  pt_x,
        input  pt_y,
        input  pt_blank,
        output pt_ready
    );
endinterface

// File: rtl/vector_point_sequencer.sv
// Vector point sequencer: takes one destination point at a time, loads it into
// the line stepper, then steps the line one pixel at a time. After every step
// it writes only the axis that moved to the dual-channel DAC and waits for the
// DAC to go idle again. Blanked moves can be followed by a settle hold so the
// deflection amplifiers catch up before the beam is lit again.
module vector_point_sequencer #(
    parameter int BITS          = 12,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_BITS      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_point_sequencer_if.slave pt,
    input  logic                   enable,
    output logic                   lt_strobe,
    output logic                   lt_next,
    output logic [BITS-1:0]        lt_x_in,
    output logic [BITS-1:0]        lt_y_in,
    input  logic                   lt_ready,
    input  logic                   lt_axis,
    input  logic [BITS-1:0]        lt_x,
    input  logic [BITS-1:0]        lt_y,
    output logic                   dac_strobe,
    output logic                   dac_axis,
    output logic [BITS-1:0]        dac_value,
    input  logic                   dac_ready,
    output logic                   blank,
    output logic                   busy,
    output logic [CNT_BITS-1:0]    points_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DWAIT  = 3'd5;
    localparam logic [2:0] S_SETTLE = 3'd6;

    localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);
    // Counter only needs to hold SETTLE_CYCLES-1
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = HAS_SETTLE ? SW'(SETTLE_CYCLES - 1) : '0;

    logic [2:0]      state;
    logic [BITS-1:0] dst_x;
    logic [BITS-1:0] dst_y;
    logic            dst_blank;
    logic [SW-1:0]   settle_cnt;

    logic pt_ready_int;
    logic accept;
    logic line_done;
    logic step_go;

    // Ready is forced low for as long as reset is held, not just after the edge
    assign pt_ready_int = (state == S_IDLE) && !reset;
    assign pt.pt_ready  = pt_ready_int;
    assign accept       = pt.pt_valid && pt_ready_int;

    // Stepper reports arrival: the line (possibly zero-length) is finished
    assign line_done = (state == S_CHECK) && lt_ready;
    // Next step only when the previous DAC write has fully drained
    assign step_go   = (state == S_CHECK) && !lt_ready && enable && dac_ready;

    // Destination is presented to the stepper continuously; it samples on lt_strobe
    assign lt_x_in = dst_x;
    assign lt_y_in = dst_y;

    // Strobes and DAC payload are pure state decodes, so they can never overlap
    always_comb begin
        lt_strobe  = (state == S_LOAD);
        lt_next    = step_go;
        dac_strobe = (state == S_WRITE);
        // Stepper outputs already hold the post-step position in WRITE
        dac_axis   = lt_axis;
        dac_value  = lt_axis ? lt_y : lt_x;
        busy       = (state != S_IDLE);
    end

    // Sequencer control: load, step/write/wait loop, optional settle hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (lt_ready) begin
                        state <= (dst_blank && HAS_SETTLE) ? S_SETTLE : S_IDLE;
                    end else if (enable && dac_ready) begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state <= S_GAP;
                end
                // DAC ready lags its strobe by a cycle, so it is ignored here
                S_GAP: begin
                    state <= S_DWAIT;
                end
                S_DWAIT: begin
                    if (dac_ready) begin
                        state <= S_CHECK;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the accepted destination; zero after reset so the stepper homes to (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_x     <= '0;
            dst_y     <= '0;
            dst_blank <= 1'b1;
        end else if (accept) begin
            dst_x     <= pt.pt_x;
            dst_y     <= pt.pt_y;
            dst_blank <= pt.pt_blank;
        end
    end

    // Beam blank follows the point's blank flag from LOAD onward; dark out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank <= 1'b1;
        end else if (state == S_LOAD) begin
            blank <= dst_blank;
        end
    end

    // Completed-point counter, wrapping naturally at its width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            points_done <= '0;
        end else if (line_done) begin
            points_done <= points_done + 1'b1;
        end
    end

    // Settle hold counter: loaded as a blanked line finishes, counts down to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (line_done && dst_blank && HAS_SETTLE) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_point_sequencer.sv
// Testbench for vector_point_sequencer: behavioural line stepper and DAC
// around the DUT, a path-level scoreboard of expected DAC writes, and
// directed cases with hand-computed literal expectations.
module tb_vector_point_sequencer;

    localparam int BITS   = 12;
    localparam int SETTLE = 8;
    localparam int CNTW   = 16;

    typedef logic [BITS:0] wr_t;   // {axis, value}

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vector_point_sequencer_if #(.BITS(BITS)) pt_if ();

    logic            enable;
    logic            lt_strobe, lt_next, lt_ready, lt_axis;
    logic [BITS-1:0] lt_x_in, lt_y_in, lt_x, lt_y;
    logic            dac_strobe, dac_axis, dac_ready;
    logic [BITS-1:0] dac_value;
    logic            blank, busy;
    logic [CNTW-1:0] points_done;

    vector_point_sequencer #(
        .BITS(BITS), .SETTLE_CYCLES(SETTLE), .CNT_BITS(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .pt(pt_if), .enable(enable),
        .lt_strobe(lt_strobe), .lt_next(lt_next), .lt_x_in(lt_x_in), .lt_y_in(lt_y_in),
        .lt_ready(lt_ready), .lt_axis(lt_axis), .lt_x(lt_x), .lt_y(lt_y),
        .dac_strobe(dac_strobe), .dac_axis(dac_axis), .dac_value(dac_value),
        .dac_ready(dac_ready), .blank(blank), .busy(busy), .points_done(points_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int toward(input int p, input int d);
        return (d > p) ? p + 1 : p - 1;
    endfunction

    // 4-connected line rule: move X while it is not ahead of the ideal slope
    function automatic bit pick_x(input int dx, input int dy, input int nx, input int ny);
        if (nx >= dx) return 1'b0;
        if (ny >= dy) return 1'b1;
        return (nx * dy <= ny * dx);
    endfunction

    // ---------------- line stepper model ----------------
    logic [BITS-1:0] st_x, st_y, st_dx, st_dy;
    int              st_sx, st_sy, st_nx, st_ny;
    logic            st_axis;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st_x <= '0; st_y <= '0; st_dx <= '0; st_dy <= '0;
            st_sx <= 0; st_sy <= 0; st_nx <= 0; st_ny <= 0; st_axis <= 1'b0;
        end else if (lt_strobe) begin
            st_dx <= lt_x_in; st_dy <= lt_y_in;
            st_sx <= int'(st_x); st_sy <= int'(st_y);
            st_nx <= 0; st_ny <= 0;
        end else if (lt_next && !((st_x == st_dx) && (st_y == st_dy))) begin
            if (pick_x(iabs(int'(st_dx) - st_sx), iabs(int'(st_dy) - st_sy), st_nx, st_ny)) begin
                st_x <= BITS'(toward(int'(st_x), int'(st_dx)));
                st_axis <= 1'b0;
                st_nx <= st_nx + 1;
            end else begin
                st_y <= BITS'(toward(int'(st_y), int'(st_dy)));
                st_axis <= 1'b1;
                st_ny <= st_ny + 1;
            end
        end
    end

    assign lt_x     = st_x;
    assign lt_y     = st_y;
    assign lt_axis  = st_axis;
    assign lt_ready = (st_x == st_dx) && (st_y == st_dy);

    // ---------------- DAC model: ready drops one cycle after the strobe ----------------
    logic dac_lag;
    int   dac_busy;
    int   dac_len   = 32;
    bit   rand_mode = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_lag  <= 1'b0;
            dac_busy <= 0;
        end else begin
            dac_lag <= dac_strobe;
            if (dac_lag) dac_busy <= rand_mode ? int'($urandom_range(1, 6)) : dac_len;
            else if (dac_busy > 0) dac_busy <= dac_busy - 1;
        end
    end

    assign dac_ready = (dac_busy == 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    wr_t  exp_q[$];
    wr_t  wr_log[$];
    int   wr_cyc[$];
    wr_t  got_w, exp_w;
    logic acc_prev    = 1'b0;
    logic outstanding = 1'b0;
    logic cur_blank   = 1'b1;
    int   acc_count   = 0;
    int   n_strobes;

    // Every DAC write along the path: the moved axis and its new coordinate
    task automatic push_path(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, nx, ny, x, y;
        dx = iabs(x1 - x0); dy = iabs(y1 - y0);
        nx = 0; ny = 0; x = x0; y = y0;
        while ((nx < dx) || (ny < dy)) begin
            if (pick_x(dx, dy, nx, ny)) begin
                x = toward(x, x1); nx++;
                exp_q.push_back({1'b0, BITS'(x)});
            end else begin
                y = toward(y, y1); ny++;
                exp_q.push_back({1'b1, BITS'(y)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_prev    = 1'b0;
            outstanding = 1'b0;
            acc_count   = 0;
        end else begin
            n_strobes = int'(lt_strobe) + int'(lt_next) + int'(dac_strobe);
            chk("strobe_overlap", n_strobes > 1, 0);
            chk("ready_vs_busy", pt_if.pt_ready, !busy);
            chk("lt_strobe_timing", lt_strobe, acc_prev);
            if (outstanding && pt_if.pt_ready) begin
                chk("points_done", points_done, acc_count[CNTW-1:0]);
                chk("writes_left", exp_q.size(), 0);
                chk("blank_idle", blank, cur_blank);
                outstanding = 1'b0;
            end
            if (outstanding && !lt_strobe) chk("blank_during_move", blank, cur_blank);
            if (lt_next) begin
                chk("next_enable", enable, 1);
                chk("next_dac_ready", dac_ready, 1);
                chk("next_not_arrived", lt_ready, 0);
            end
            if (dac_strobe) begin
                got_w = {dac_axis, dac_value};
                wr_log.push_back(got_w);
                wr_cyc.push_back(cyc);
                chk("dac_idle_at_write", (dac_busy == 0) && !dac_lag, 1);
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    chk("dac_write", got_w, exp_w);
                end
            end
            acc_prev = pt_if.pt_valid && pt_if.pt_ready;
            if (acc_prev) begin
                push_path(int'(st_x), int'(st_y), int'(pt_if.pt_x), int'(pt_if.pt_y));
                cur_blank   = pt_if.pt_blank;
                acc_count++;
                outstanding = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_point(input int x, input int y, input logic b);
        int n;
        n = 0;
        @(posedge clk); #1;
        pt_if.pt_valid = 1'b1;
        pt_if.pt_x = BITS'(x); pt_if.pt_y = BITS'(y); pt_if.pt_blank = b;
        do begin
            @(negedge clk); n++;
        end while (!pt_if.pt_ready && n < 200);
        chk("accept_ready", pt_if.pt_ready, 1);
        @(posedge clk); #1;
        pt_if.pt_valid = 1'b0;
    endtask

    // Cycle-exact view of T+1..T+3 after an accept at T
    task automatic timing_check(input bit zero, input logic b);
        @(negedge clk);
        chk("t1_lt_strobe", lt_strobe, 1);
        @(negedge clk);
        chk("t2_busy", busy, 1);
        chk("t2_blank", blank, b);
        chk("t2_quiet", {lt_strobe, dac_strobe}, 0);
        @(negedge clk);
        if (zero) begin
            chk("t3_ready", pt_if.pt_ready, 1);
            chk("t3_no_write", dac_strobe, 0);
        end else begin
            chk("t3_dac_strobe", dac_strobe, 1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!pt_if.pt_ready && n < budget) begin
            @(negedge clk); n++;
        end
        chk("idle_reached", pt_if.pt_ready, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("rst_points_done", points_done, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_log(input string name, input wr_t exp[$]);
        chk({name, "_count"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wr_log.size(); i++) chk(name, wr_log[i], exp[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wr_t lit[$];
        enable = 1'b1;
        pt_if.pt_valid = 1'b1; pt_if.pt_x = 12'd5; pt_if.pt_y = 12'd7; pt_if.pt_blank = 1'b0;

        // Reset held with stimulus active
        repeat (3) @(negedge clk);
        chk("rst_blank", blank, 1);
        chk("rst_pt_ready", pt_if.pt_ready, 0);
        chk("rst_strobes", {lt_strobe, lt_next, dac_strobe}, 0);
        chk("rst_points_done", points_done, 0);
        @(posedge clk); #1; reset = 1'b0; pt_if.pt_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", pt_if.pt_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_blank", blank, 1);
        chk("post_rst_lt_x_in", lt_x_in, 0);
        chk("post_rst_lt_y_in", lt_y_in, 0);

        // Lit (3,0) from (0,0)
        wr_log.delete(); wr_cyc.delete();
        send_point(3, 0, 1'b0);
        timing_check(1'b0, 1'b0);
        wait_idle(2000);
        lit = '{{1'b0, 12'd1}, {1'b0, 12'd2}, {1'b0, 12'd3}};
        check_log("line30", lit);
        chk("line30_done", points_done, 1);
        chk("line30_blank", blank, 0);
        // WRITE, GAP, dac_len busy cycles plus the ready cycle in DWAIT, CHECK
        if (wr_cyc.size() >= 2) chk("write_spacing", wr_cyc[1] - wr_cyc[0], dac_len + 4);

        // Lit (2,2) from (0,0)
        pulse_reset();
        wr_log.delete();
        send_point(2, 2, 1'b0);
        timing_check(1'b0, 1'b0);
        wait_idle(2000);
        lit = '{{1'b0, 12'd1}, {1'b1, 12'd1}, {1'b0, 12'd2}, {1'b1, 12'd2}};
        check_log("line22", lit);

        // Blanked (10,0) from (0,0) with settle hold
        pulse_reset();
        wr_log.delete();
        send_point(10, 0, 1'b1);
        n = 0;
        while (points_done != 1 && n < 2000) begin @(negedge clk); n++; end
        chk("blank_line_done", points_done, 1);
        n = 0;
        while (!pt_if.pt_ready && n < 100) begin n++; @(negedge clk); end
        chk("settle_len", n, SETTLE);
        chk("blank_after_settle", blank, 1);
        chk("blank_line_writes", wr_log.size(), 10);

        // Zero-length point at the current position
        wr_log.delete();
        send_point(10, 0, 1'b0);
        timing_check(1'b1, 1'b0);
        chk("zero_done", points_done, 2);
        chk("zero_writes", wr_log.size(), 0);

        // Pause with enable during the 5th write of a long line
        pulse_reset();
        wr_log.delete();
        send_point(100, 0, 1'b0);
        n = 0;
        while (wr_log.size() < 5 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #1; enable = 1'b0;
        n = 0;
        repeat (80) begin @(negedge clk); n += int'(lt_next) + int'(dac_strobe); end
        chk("paused_activity", n, 0);
        chk("paused_writes", wr_log.size(), 5);
        @(posedge clk); #1; enable = 1'b1;
        wait_idle(6000);
        chk("long_line_writes", wr_log.size(), 100);
        chk("long_line_done", points_done, 1);

        // Asynchronous reset in the middle of a line
        wr_log.delete();
        send_point(0, 0, 1'b0);
        n = 0;
        while (wr_log.size() < 10 && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk); #2; reset = 1'b1; #1;
        chk("midrst_blank", blank, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", pt_if.pt_ready, 0);
        chk("midrst_strobes", {lt_strobe, lt_next, dac_strobe}, 0);
        chk("midrst_points_done", points_done, 0);
        @(negedge clk);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", pt_if.pt_ready, 1);
        chk("midrst_lt_x_in", lt_x_in, 0);

        // Randomized points, enable and DAC busy times
        rand_mode = 1'b1;
        repeat (3000) begin
            @(posedge clk); #1;
            pt_if.pt_valid = ($urandom_range(0, 3) == 0);
            pt_if.pt_x     = BITS'($urandom_range(0, 15));
            pt_if.pt_y     = BITS'($urandom_range(0, 15));
            pt_if.pt_blank = $urandom_range(0, 2) == 0;
            enable         = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk); #1;
        pt_if.pt_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        wait_idle(3000);
        repeat (2) @(negedge clk);
        chk("random_points_done", points_done, acc_count[CNTW-1:0]);
        chk("random_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
